// File: rtl/ccip_rd_engine_pkg.sv
// CCI-P channel-0 types shared by the read engine: header layouts, encodings,
// the read-engine state encoding and the line-count to cl_len mapping.
package ccip_rd_engine_pkg;

  localparam int CCIP_CLADDR_WIDTH = 42;
  localparam int CCIP_MDATA_WIDTH  = 16;

  typedef logic [CCIP_CLADDR_WIDTH-1:0] t_ccip_clAddr;
  typedef logic [CCIP_MDATA_WIDTH-1:0]  t_ccip_mdata;
  typedef logic [1:0]                   t_ccip_clNum;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    t_ccip_clNum  cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  localparam int CCIP_C0TX_HDR_WIDTH = $bits(t_ccip_c0_ReqMemHdr);
  localparam int CCIP_C0RX_HDR_WIDTH = $bits(t_ccip_c0_RspMemHdr);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2,
    RD_DONE  = 2'd3
  } t_ccip_rd_state;

  function automatic t_ccip_clLen ccip_lines_to_cl_len(input logic [2:0] n);
    case (n)
      3'd4:    return eCL_LEN_4;
      3'd2:    return eCL_LEN_2;
      default: return eCL_LEN_1;
    endcase
  endfunction

endpackage

// File: rtl/ccip_burst_sel.sv
// Picks the largest naturally aligned multi-CL burst (1, 2 or 4 lines) that
// fits in the remaining line count.
module ccip_burst_sel
  import ccip_rd_engine_pkg::*;
#(
  parameter int LEN_WIDTH = 16,
  parameter int MAX_BURST = 4
) (
  input  logic [1:0]       addr_lo,
  input  logic [LEN_WIDTH:0] r,
  output logic [2:0]       len,
  output t_ccip_clLen      cl_len
);

  always_comb begin
    len = 3'd1;
    if (MAX_BURST >= 4 && addr_lo == 2'b00 && r >= (LEN_WIDTH+1)'(4))
      len = 3'd4;
    else if (MAX_BURST >= 2 && !addr_lo[0] && r >= (LEN_WIDTH+1)'(2))
      len = 3'd2;
  end

  assign cl_len = ccip_lines_to_cl_len(len);

endmodule

// File: rtl/ccip_rd_engine.sv
// CCI-P c0 read engine: splits a (start address, line count) command into
// aligned multi-CL reads under almost-full and outstanding-line credit limits.
module ccip_rd_engine
  import ccip_rd_engine_pkg::*;
#(
  parameter int       CLADDR_WIDTH    = 42,
  parameter int       CLDATA_WIDTH    = 512,
  parameter int       LEN_WIDTH       = 16,
  parameter int       MAX_BURST       = 4,
  parameter int       MAX_OUTSTANDING = 64,
  parameter t_ccip_vc VC_SEL          = eVC_VA
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CLADDR_WIDTH-1:0]  cmd_addr,
  input  logic [LEN_WIDTH-1:0]     cmd_lines,
  output logic                     c0_tx_valid,
  output t_ccip_c0_ReqMemHdr       c0_tx_hdr,
  input  logic                     c0_tx_almfull,
  input  logic                     c0_rx_rspValid,
  input  t_ccip_c0_RspMemHdr       c0_rx_hdr,
  input  logic [CLDATA_WIDTH-1:0]  c0_rx_data,
  output logic                     rsp_valid,
  output logic [LEN_WIDTH-1:0]     rsp_idx,
  output logic [CLDATA_WIDTH-1:0]  rsp_data,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] ST_IDLE  = RD_IDLE;
  localparam logic [1:0] ST_ISSUE = RD_ISSUE;
  localparam logic [1:0] ST_DRAIN = RD_DRAIN;
  localparam logic [1:0] ST_DONE  = RD_DONE;

  // Handshakes: cmd is taken on a cycle where cmd_valid && cmd_ready; c0_tx_valid
  // and rsp_valid are single-cycle strobes with no back-pressure, throttling is
  // done before issue via c0_tx_almfull and the outstanding-line credit.

  logic [1:0]              state;
  logic [CLADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH:0]      lines_q;
  logic [LEN_WIDTH:0]      issued_cnt;
  logic [LEN_WIDTH:0]      returned_cnt;
  logic [LEN_WIDTH:0]      remaining;
  logic [LEN_WIDTH:0]      outstanding;
  logic [31:0]             credit_need;
  logic [2:0]              len;
  t_ccip_clLen             cl_len;
  logic                    issue_go;
  logic                    rsp_take;
  t_ccip_c0_ReqMemHdr      req_hdr;
  logic                    unused_rx_hdr;

  assign remaining   = lines_q - issued_cnt;
  assign outstanding = issued_cnt - returned_cnt;
  assign credit_need = 32'(outstanding) + 32'(len);

  ccip_burst_sel #(
    .LEN_WIDTH (LEN_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) u_burst_sel (
    .addr_lo (addr_q[1:0]),
    .r       (remaining),
    .len     (len),
    .cl_len  (cl_len)
  );

  assign issue_go = (state == ST_ISSUE) && (issued_cnt != lines_q) && !c0_tx_almfull
                    && (credit_need <= 32'(MAX_OUTSTANDING));

  // Late responses from a command aborted by reset land in IDLE and are dropped.
  assign rsp_take = c0_rx_rspValid && (c0_rx_hdr.resp_type == eRSP_RDLINE)
                    && ((state == ST_ISSUE) || (state == ST_DRAIN));

  always_comb begin
    req_hdr          = '0;
    req_hdr.vc_sel   = VC_SEL;
    req_hdr.cl_len   = cl_len;
    req_hdr.req_type = eREQ_RDLINE_I;
    req_hdr.address  = t_ccip_clAddr'(addr_q);
    req_hdr.mdata    = t_ccip_mdata'(issued_cnt[LEN_WIDTH-1:0]);
  end

  assign unused_rx_hdr = ^c0_rx_hdr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      lines_q      <= '0;
      issued_cnt   <= '0;
      returned_cnt <= '0;
      c0_tx_valid  <= 1'b0;
      c0_tx_hdr    <= '0;
      rsp_valid    <= 1'b0;
      rsp_idx      <= '0;
      rsp_data     <= '0;
    end else begin
      c0_tx_valid <= issue_go;
      rsp_valid   <= rsp_take;
      if (issue_go) begin
        c0_tx_hdr  <= req_hdr;
        issued_cnt <= issued_cnt + (LEN_WIDTH+1)'(len);
        addr_q     <= addr_q + CLADDR_WIDTH'(len);
      end
      if (rsp_take) begin
        rsp_idx      <= c0_rx_hdr.mdata[LEN_WIDTH-1:0] + LEN_WIDTH'(c0_rx_hdr.cl_num);
        rsp_data     <= c0_rx_data;
        returned_cnt <= returned_cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q       <= cmd_addr;
            lines_q      <= {1'b0, cmd_lines};
            issued_cnt   <= '0;
            returned_cnt <= '0;
            state        <= (cmd_lines == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: if (issued_cnt == lines_q) state <= ST_DRAIN;
        ST_DRAIN: if (returned_cnt == lines_q) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_ccip_rd_engine.sv
// Directed bench for ccip_rd_engine: a default-credit instance (a) and a
// 4-line-credit instance (b) share all inputs.
module tb_ccip_rd_engine;
  import ccip_rd_engine_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic [41:0]        cmd_addr;
  logic [15:0]        cmd_lines;
  logic               almfull;
  logic               rx_valid;
  t_ccip_c0_RspMemHdr rx_hdr;
  logic [511:0]       rx_data;

  logic a_cmd_ready, a_tx_valid, a_rsp_valid, a_busy, a_done;
  t_ccip_c0_ReqMemHdr a_tx_hdr;
  logic [15:0] a_rsp_idx;
  logic [511:0] a_rsp_data;
  logic [1:0] a_dbg;

  logic b_cmd_ready, b_tx_valid, b_rsp_valid, b_busy, b_done;
  t_ccip_c0_ReqMemHdr b_tx_hdr;
  logic [15:0] b_rsp_idx;
  logic [511:0] b_rsp_data;
  logic [1:0] b_dbg;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  t_ccip_c0_ReqMemHdr req_a_q[$];
  t_ccip_c0_ReqMemHdr req_b_q[$];
  logic [15:0] got_idx_q[$];
  logic [15:0] got_dat_q[$];
  logic [15:0] exp_q[$];

  ccip_rd_engine dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_addr(cmd_addr), .cmd_lines(cmd_lines), .c0_tx_valid(a_tx_valid),
    .c0_tx_hdr(a_tx_hdr), .c0_tx_almfull(almfull), .c0_rx_rspValid(rx_valid),
    .c0_rx_hdr(rx_hdr), .c0_rx_data(rx_data), .rsp_valid(a_rsp_valid),
    .rsp_idx(a_rsp_idx), .rsp_data(a_rsp_data), .busy(a_busy), .done(a_done),
    .dbg_state(a_dbg)
  );

  ccip_rd_engine #(.MAX_OUTSTANDING(4)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_addr(cmd_addr), .cmd_lines(cmd_lines), .c0_tx_valid(b_tx_valid),
    .c0_tx_hdr(b_tx_hdr), .c0_tx_almfull(almfull), .c0_rx_rspValid(rx_valid),
    .c0_rx_hdr(rx_hdr), .c0_rx_data(rx_data), .rsp_valid(b_rsp_valid),
    .rsp_idx(b_rsp_idx), .rsp_data(b_rsp_data), .busy(b_busy), .done(b_done),
    .dbg_state(b_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (a_tx_valid) req_a_q.push_back(a_tx_hdr);
    if (b_tx_valid) req_b_q.push_back(b_tx_hdr);
    if (a_rsp_valid) begin
      got_idx_q.push_back(a_rsp_idx);
      got_dat_q.push_back(a_rsp_data[15:0]);
    end
    if (a_done) done_cnt++;
  end

  // Driver tasks; all return 1 time unit after a rising edge
  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_lines = '0;
    almfull = 1'b0; rx_valid = 1'b0; rx_hdr = '0; rx_data = '0;
    repeat (2) @(posedge clk);
    req_a_q.delete(); req_b_q.delete(); got_idx_q.delete(); got_dat_q.delete();
    exp_q.delete(); done_cnt = 0;
    #1 reset = 1'b0;
  endtask

  task automatic send_cmd(input logic [41:0] ad, input logic [15:0] n);
    cmd_addr = ad; cmd_lines = n; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [15:0] md, input logic [1:0] cl,
                          input t_ccip_c0_rsp rt, input logic [15:0] d);
    rx_hdr = '0; rx_hdr.mdata = md; rx_hdr.cl_num = cl; rx_hdr.resp_type = rt;
    rx_data = {496'h0, d}; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Scoreboard drain: compare returned lines against exp_q in order
  task automatic check_rsps(input string name, input int n);
    if (got_idx_q.size() !== n) begin
      bad++; $display("FAIL %s_count got=%0d exp=%0d", name, got_idx_q.size(), n);
    end
    total++;
    while (exp_q.size() > 0 && got_idx_q.size() > 0) begin
      logic [15:0] e, gi, gd;
      e = exp_q.pop_front(); gi = got_idx_q.pop_front(); gd = got_dat_q.pop_front();
      if (gi !== e) begin
        bad++; $display("FAIL %s_idx got=%0d exp=%0d", name, gi, e);
      end
      total++;
      if (gd !== 16'hD000 + e) begin
        bad++; $display("FAIL %s_data got=%h exp=%h", name, gd, 16'hD000 + e);
      end
      total++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; almfull = 1'b0; rx_valid = 1'b0;
    rx_hdr = '0; rx_data = '0; cmd_addr = '0; cmd_lines = '0;
    repeat (2) @(posedge clk); #1;
    if ({a_cmd_ready, a_busy, a_done, a_tx_valid, a_rsp_valid} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=10000",
                      {a_cmd_ready, a_busy, a_done, a_tx_valid, a_rsp_valid});
    end
    total++;
    if (a_tx_hdr !== '0 || a_rsp_idx !== 16'd0 || a_rsp_data !== '0) begin
      bad++; $display("FAIL reset_data got hdr=%h idx=%0d exp 0", a_tx_hdr, a_rsp_idx);
    end
    total++;
    if (a_dbg !== 2'd0) begin
      bad++; $display("FAIL reset_state got=%0d exp=0", a_dbg);
    end
    total++;
    reset = 1'b0;
    @(posedge clk); #1;
    if (a_cmd_ready !== 1'b1 || a_busy !== 1'b0) begin
      bad++; $display("FAIL reset_release got ready=%b busy=%b exp 1 0", a_cmd_ready, a_busy);
    end
    total++;
  endtask

  task automatic test_split_7();
    logic [41:0] ea[3] = '{42'h100, 42'h104, 42'h106};
    t_ccip_clLen el[3] = '{eCL_LEN_4, eCL_LEN_2, eCL_LEN_1};
    logic [15:0] em[3] = '{16'd0, 16'd4, 16'd6};
    do_reset();
    send_cmd(42'h100, 16'd7);
    if (a_busy !== 1'b1 || a_cmd_ready !== 1'b0) begin
      bad++; $display("FAIL split_accept got busy=%b ready=%b exp 1 0", a_busy, a_cmd_ready);
    end
    total++;
    for (int i = 0; i < 40 && req_a_q.size() < 3; i++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    if (req_a_q.size() !== 3) begin
      bad++; $display("FAIL split_nreq got=%0d exp=3", req_a_q.size());
    end
    total++;
    for (int i = 0; i < 3 && i < req_a_q.size(); i++) begin
      if (req_a_q[i].address !== ea[i] || req_a_q[i].cl_len !== el[i] || req_a_q[i].mdata !== em[i]) begin
        bad++; $display("FAIL split_req%0d got addr=%h len=%0d md=%0d exp addr=%h len=%0d md=%0d",
                        i, req_a_q[i].address, req_a_q[i].cl_len, req_a_q[i].mdata, ea[i], el[i], em[i]);
      end
      total++;
      if (req_a_q[i].req_type !== eREQ_RDLINE_I || req_a_q[i].vc_sel !== eVC_VA ||
          req_a_q[i].rsvd0 !== 6'd0 || req_a_q[i].rsvd1 !== 2'd0) begin
        bad++; $display("FAIL split_hdr%0d got type=%0d vc=%0d exp 0 0", i, req_a_q[i].req_type, req_a_q[i].vc_sel);
      end
      total++;
    end
    if (a_dbg !== 2'd2) begin
      bad++; $display("FAIL split_drain got=%0d exp=2", a_dbg);
    end
    total++;
    send_rsp(16'd0, 2'd0, eRSP_UMSG, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      send_rsp(16'd0, 2'(i), eRSP_RDLINE, 16'hD000 + 16'(i)); exp_q.push_back(16'(i));
    end
    send_rsp(16'd4, 2'd0, eRSP_RDLINE, 16'hD004); exp_q.push_back(16'd4);
    send_rsp(16'd4, 2'd1, eRSP_RDLINE, 16'hD005); exp_q.push_back(16'd5);
    if (done_cnt !== 0) begin
      bad++; $display("FAIL split_early_done got=%0d exp=0", done_cnt);
    end
    total++;
    send_rsp(16'd6, 2'd0, eRSP_RDLINE, 16'hD006); exp_q.push_back(16'd6);
    for (int i = 0; i < 20 && done_cnt == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    if (done_cnt !== 1) begin
      bad++; $display("FAIL split_done got=%0d exp=1", done_cnt);
    end
    total++;
    if (a_busy !== 1'b0 || a_cmd_ready !== 1'b1) begin
      bad++; $display("FAIL split_idle got busy=%b ready=%b exp 0 1", a_busy, a_cmd_ready);
    end
    total++;
    check_rsps("split", 7);
  endtask

  task automatic test_unaligned_reverse();
    logic [41:0] ea[3] = '{42'h101, 42'h102, 42'h104};
    t_ccip_clLen el[3] = '{eCL_LEN_1, eCL_LEN_2, eCL_LEN_1};
    logic [15:0] em[3] = '{16'd0, 16'd1, 16'd3};
    do_reset();
    send_cmd(42'h101, 16'd4);
    for (int i = 0; i < 40 && req_a_q.size() < 3; i++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    if (req_a_q.size() !== 3) begin
      bad++; $display("FAIL unal_nreq got=%0d exp=3", req_a_q.size());
    end
    total++;
    for (int i = 0; i < 3 && i < req_a_q.size(); i++) begin
      if (req_a_q[i].address !== ea[i] || req_a_q[i].cl_len !== el[i] || req_a_q[i].mdata !== em[i]) begin
        bad++; $display("FAIL unal_req%0d got addr=%h len=%0d md=%0d exp addr=%h len=%0d md=%0d",
                        i, req_a_q[i].address, req_a_q[i].cl_len, req_a_q[i].mdata, ea[i], el[i], em[i]);
      end
      total++;
    end
    send_rsp(16'd3, 2'd0, eRSP_RDLINE, 16'hD003); exp_q.push_back(16'd3);
    send_rsp(16'd1, 2'd1, eRSP_RDLINE, 16'hD002); exp_q.push_back(16'd2);
    send_rsp(16'd1, 2'd0, eRSP_RDLINE, 16'hD001); exp_q.push_back(16'd1);
    send_rsp(16'd0, 2'd0, eRSP_RDLINE, 16'hD000); exp_q.push_back(16'd0);
    for (int i = 0; i < 20 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    if (done_cnt !== 1) begin
      bad++; $display("FAIL unal_done got=%0d exp=1", done_cnt);
    end
    total++;
    check_rsps("unal", 4);
  endtask

  task automatic test_credit_limit();
    do_reset();
    send_cmd(42'h200, 16'd8);
    repeat (20) @(posedge clk); #1;
    if (req_b_q.size() !== 1) begin
      bad++; $display("FAIL credit_nreq got=%0d exp=1", req_b_q.size());
    end
    total++;
    if (req_b_q.size() > 0 && (req_b_q[0].cl_len !== eCL_LEN_4 || req_b_q[0].address !== 42'h200)) begin
      bad++; $display("FAIL credit_first got len=%0d addr=%h exp len=3 addr=200",
                      req_b_q[0].cl_len, req_b_q[0].address);
    end
    total++;
    if (b_dbg !== 2'd1) begin
      bad++; $display("FAIL credit_state got=%0d exp=1", b_dbg);
    end
    total++;
    for (int i = 0; i < 4; i++) send_rsp(16'd0, 2'(i), eRSP_RDLINE, 16'hD000 + 16'(i));
    repeat (2) @(posedge clk); #1;
    if (req_b_q.size() !== 2) begin
      bad++; $display("FAIL credit_resume got=%0d exp=2", req_b_q.size());
    end
    total++;
    if (req_b_q.size() > 1 && (req_b_q[1].address !== 42'h204 || req_b_q[1].mdata !== 16'd4)) begin
      bad++; $display("FAIL credit_second got addr=%h md=%0d exp addr=204 md=4",
                      req_b_q[1].address, req_b_q[1].mdata);
    end
    total++;
  endtask

  task automatic test_almfull();
    bit seen = 0;
    int win_cnt = 0;
    do_reset();
    send_cmd(42'h300, 16'd16);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_tx_valid) begin
        almfull = 1'b1; seen = 1; break;
      end
    end
    if (seen !== 1'b1) begin
      bad++; $display("FAIL almfull_first got=0 exp=1");
    end
    total++;
    repeat (10) begin
      @(negedge clk);
      if (a_tx_valid) win_cnt++;
    end
    almfull = 1'b0;
    @(negedge clk);
    if (win_cnt !== 0) begin
      bad++; $display("FAIL almfull_window got=%0d exp=0", win_cnt);
    end
    total++;
    if (a_tx_valid !== 1'b1) begin
      bad++; $display("FAIL almfull_resume got=%b exp=1", a_tx_valid);
    end
    total++;
    for (int i = 0; i < 30 && req_a_q.size() < 4; i++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    if (req_a_q.size() !== 4) begin
      bad++; $display("FAIL almfull_nreq got=%0d exp=4", req_a_q.size());
    end
    total++;
    for (int i = 0; i < 4 && i < req_a_q.size(); i++) begin
      if (req_a_q[i].address !== 42'h300 + 42'(4 * i) || req_a_q[i].cl_len !== eCL_LEN_4) begin
        bad++; $display("FAIL almfull_req%0d got addr=%h len=%0d exp addr=%h len=3",
                        i, req_a_q[i].address, req_a_q[i].cl_len, 42'h300 + 42'(4 * i));
      end
      total++;
    end
  endtask

  task automatic test_zero_lines();
    do_reset();
    send_cmd(42'h500, 16'd0);
    if (a_done !== 1'b1 || a_busy !== 1'b1 || a_cmd_ready !== 1'b0) begin
      bad++; $display("FAIL zero_done got done=%b busy=%b ready=%b exp 1 1 0", a_done, a_busy, a_cmd_ready);
    end
    total++;
    @(posedge clk); #1;
    if (a_done !== 1'b0 || a_cmd_ready !== 1'b1) begin
      bad++; $display("FAIL zero_idle got done=%b ready=%b exp 0 1", a_done, a_cmd_ready);
    end
    total++;
    repeat (5) @(posedge clk); #1;
    if (req_a_q.size() !== 0 || done_cnt !== 1) begin
      bad++; $display("FAIL zero_noreq got reqs=%0d dones=%0d exp 0 1", req_a_q.size(), done_cnt);
    end
    total++;
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    send_cmd(42'h400, 16'd2);
    for (int i = 0; i < 20 && req_a_q.size() < 1; i++) @(posedge clk);
    repeat (2) @(posedge clk); #1;
    if (a_dbg !== 2'd2) begin
      bad++; $display("FAIL rstdrain_state got=%0d exp=2", a_dbg);
    end
    total++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    if (a_cmd_ready !== 1'b1 || a_busy !== 1'b0) begin
      bad++; $display("FAIL rstdrain_async got ready=%b busy=%b exp 1 0", a_cmd_ready, a_busy);
    end
    total++;
    @(posedge clk); #1;
    reset = 1'b0;
    send_rsp(16'd0, 2'd0, eRSP_RDLINE, 16'hD000);
    send_rsp(16'd0, 2'd1, eRSP_RDLINE, 16'hD001);
    repeat (4) @(posedge clk); #1;
    if (got_idx_q.size() !== 0 || done_cnt !== 0) begin
      bad++; $display("FAIL rstdrain_late got rsps=%0d dones=%0d exp 0 0", got_idx_q.size(), done_cnt);
    end
    total++;
    if (a_cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rstdrain_ready got=%b exp=1", a_cmd_ready);
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_split_7();
    test_unaligned_reverse();
    test_credit_limit();
    test_almfull();
    test_zero_lines();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccip_rd_engine.md
Name: ccip_rd_engine

Overview:
- Parametrised CCI-P channel-0 read engine. Sits between an AFU DMA/command unit and the CCI-P c0 Tx/Rx channels.
- Accepts a command (start cache-line address, line count) and splits it into aligned multi-CL read requests of 1, 2 or 4 lines.
- Throttles on almost-full and on an outstanding-line credit limit.
- Returns each response line tagged with its line offset within the command, and pulses done when every line has returned.

Parameters:
- CLADDR_WIDTH, 42, cache-line address width.
- CLDATA_WIDTH, 512, line data width.
- LEN_WIDTH, 16, command line-count width; must be <= MDATA_WIDTH (16).
- MAX_BURST, 4, largest multi-CL length used; legal values 1, 2, 4.
- MAX_OUTSTANDING, 64, maximum lines requested but not yet returned; must be >= MAX_BURST.
- VC_SEL, eVC_VA, virtual channel driven in every request header.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle and accepts a command.
- cmd_addr  in  CLADDR_WIDTH  start cache-line address.
- cmd_lines  in  LEN_WIDTH  number of lines; 0 is legal.
- c0_tx_valid  out  1  read request valid, registered.
- c0_tx_hdr  out  CCIP_C0TX_HDR_WIDTH  t_ccip_c0_ReqMemHdr, registered.
- c0_tx_almfull  in  1  c0TxAlmFull from the shell.
- c0_rx_rspValid  in  1  read response valid.
- c0_rx_hdr  in  CCIP_C0RX_HDR_WIDTH  t_ccip_c0_RspMemHdr.
- c0_rx_data  in  CLDATA_WIDTH  response line.
- rsp_valid  out  1  one returned line, registered.
- rsp_idx  out  LEN_WIDTH  line offset within the command.
- rsp_data  out  CLDATA_WIDTH  line data.
- busy  out  1  high from command acceptance until done.
- done  out  1  one-cycle pulse when the command completes.

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. State = IDLE; all counters cleared.
- Reset mid-operation discards all progress. Responses to requests issued before reset that arrive after it are dropped (engine in IDLE).
- FSM:
  - IDLE: cmd_ready = 1. A cmd_valid && cmd_ready handshake latches addr/lines, clears issued_cnt and returned_cnt, and goes to ISSUE. If cmd_lines == 0, go to DONE instead.
  - ISSUE: at most one request per cycle. When issued_cnt == lines, go to DRAIN.
  - DRAIN: wait until returned_cnt == lines, then go to DONE.
  - DONE: done = 1 for one cycle; then go to IDLE. busy = 1 in ISSUE, DRAIN and DONE.
- Burst selection, where a = current address and r = lines - issued_cnt:
  - len 4 if MAX_BURST >= 4, a[1:0] == 0 and r >= 4;
  - else len 2 if MAX_BURST >= 2, a[0] == 0 and r >= 2;
  - else len 1.
  - cl_len encoding: 1 → eCL_LEN_1, 2 → eCL_LEN_2, 4 → eCL_LEN_4.
- Issue condition: state == ISSUE && !c0_tx_almfull && outstanding + len <= MAX_OUTSTANDING. outstanding = issued_cnt - returned_cnt.
- Request header fields: req_type = eREQ_RDLINE_I; vc_sel = VC_SEL; address = a; mdata = zero-extended issued_cnt (the burst start offset); rsvd fields = 0.
- On issue, issued_cnt += len and a += len. c0_tx_valid is high for exactly one cycle per request, one cycle after the issue decision.
- Response acceptance: accepted when c0_rx_rspValid && resp_type == eRSP_RDLINE && state is ISSUE or DRAIN.
  - Next cycle: rsp_valid = 1, rsp_idx = mdata[LEN_WIDTH-1:0] + cl_num, rsp_data = c0_rx_data.
  - returned_cnt += 1 on the same edge as acceptance.
  - Responses may arrive out of order and are not reordered.
- Responses with any other resp_type (e.g. eRSP_UMSG) are ignored.
- Simultaneous issue and response in one cycle: both counters update and outstanding is computed from the updated values. No lost credit.
- Counters are LEN_WIDTH+1 bits wide so that cmd_lines = 2^LEN_WIDTH - 1 causes no overflow.
- Address arithmetic wraps modulo 2^CLADDR_WIDTH.

Decomposition:
- Extend the shared CCI-P package with:
  - t_ccip_rd_state enum (IDLE, ISSUE, DRAIN, DONE);
  - a function mapping a line count (1/2/4) to t_ccip_clLen.
- Header structs and widths are reused from the package; nothing is redefined locally.
- One natural sub-module: ccip_burst_sel. It is combinational, takes a, r, MAX_BURST and returns len and cl_len, and is unit-testable on its own.

Test Plan:
- cmd_addr = 0x100, lines = 7, almfull = 0 → requests 4 @ 0x100 (mdata 0), 2 @ 0x104 (mdata 4), 1 @ 0x106 (mdata 6); after 7 responses, exactly one done pulse.
- cmd_addr = 0x101, lines = 4 → requests 1 @ 0x101, 2 @ 0x102, 1 @ 0x104; the mdata values in the response checks are 0, 1 and 3.
- Responses returned in reverse order, with cl_num 1 on the second line of the 2-line burst → rsp_idx sequence 3, 2, 1, 0; no line dropped or duplicated.
- MAX_OUTSTANDING = 4, lines = 8, responses withheld → exactly 4 lines issued. Release one 4-line response → next burst issued within 2 cycles.
- almfull held high for 10 cycles mid-command → zero c0_tx_valid during that window; issue resumes the cycle after almfull falls.
- lines = 0 → no request issued; done asserted 1 cycle after acceptance. Separately: reset asserted during DRAIN → cmd_ready = 1 immediately, and late responses produce no rsp_valid.
